// File: rtl/fetch_unit_pkg.sv
// Shared types and helpers for the dual-issue fetch stage: bus widths, issue-mask
// encodings, FSM states and the packet layout handed to the instruction buffer.
package fetch_unit_pkg;

    localparam int INST_W      = 32;
    localparam int PC_W        = 32;
    localparam int INST_BYTES  = 4;
    localparam int FETCH_BYTES = 8;

    typedef logic [INST_W-1:0] inst_t;
    typedef logic [PC_W-1:0]   pc_t;
    typedef logic [1:0]        issue_t;

    localparam issue_t ISSUE_NONE  = 2'b00;
    localparam issue_t ISSUE_SLOT2 = 2'b01;
    localparam issue_t ISSUE_SLOT1 = 2'b10;
    localparam issue_t ISSUE_BOTH  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_PKT
    } fsm_state_e;

    typedef struct packed {
        issue_t mask;
        inst_t  inst1;
        pc_t    pc1;
        pc_t    npc1;
        inst_t  inst2;
        pc_t    pc2;
        pc_t    npc2;
    } packet_t;

    // Start of the next 8-byte fetch block; wraps silently at the top of memory.
    function automatic pc_t next_fetch_pc(input pc_t pc);
        return {pc[PC_W-1:3], 3'b000} + pc_t'(FETCH_BYTES);
    endfunction

    // A fetch entering mid-block (pc[2]=1) only owns the upper word of the line.
    function automatic packet_t build_packet(input pc_t pc, input logic [2*INST_W-1:0] data);
        packet_t p;
        p = '0;
        if (!pc[2]) begin
            p.mask  = ISSUE_BOTH;
            p.inst1 = data[INST_W-1:0];
            p.pc1   = pc;
            p.npc1  = pc + pc_t'(INST_BYTES);
            p.inst2 = data[2*INST_W-1:INST_W];
            p.pc2   = pc + pc_t'(INST_BYTES);
            p.npc2  = pc + pc_t'(2*INST_BYTES);
        end else begin
            p.mask  = ISSUE_SLOT2;
            p.inst2 = data[2*INST_W-1:INST_W];
            p.pc2   = pc;
            p.npc2  = pc + pc_t'(INST_BYTES);
        end
        return p;
    endfunction

endpackage

// File: rtl/fetch_unit_pc_gen.sv
// Fetch PC generator: holds fetch_pc and the deferred redirect target used when a
// redirect has to wait for a stale memory request to drain.
module pc_gen
    import fetch_unit_pkg::*;
#(
    parameter pc_t RESET_PC = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic advance,
    input  logic redirect,
    input  logic restore,
    input  logic capture,
    input  pc_t  branch_pc,
    output pc_t  fetch_pc
);

    pc_t fetch_pc_d, fetch_pc_q;
    pc_t redir_pc_d, redir_pc_q;

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        redir_pc_d = redir_pc_q;
        if (redirect) begin
            fetch_pc_d = branch_pc;
        end else if (restore) begin
            fetch_pc_d = redir_pc_q;
        end else if (advance) begin
            fetch_pc_d = next_fetch_pc(fetch_pc_q);
        end
        if (capture) begin
            redir_pc_d = branch_pc;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            redir_pc_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            redir_pc_q <= redir_pc_d;
        end
    end

    assign fetch_pc = fetch_pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Dual-issue fetch stage: requests 64-bit packets from instruction memory and
// presents them to the instruction buffer, honouring back-pressure and redirects.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_flag,
    input  logic [31:0] branch_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rsp_valid,
    input  logic [63:0] imem_rsp_data,
    input  logic        instbuf_full,
    output logic [1:0]  issue,
    output logic [31:0] in1_inst,
    output logic [31:0] in1_pc,
    output logic [31:0] in1_npc,
    output logic [31:0] in2_inst,
    output logic [31:0] in2_pc,
    output logic [31:0] in2_npc
);

    fsm_state_e state_d, state_q;
    packet_t    pkt_d, pkt_q;
    logic       pkt_valid_d, pkt_valid_q;
    logic       outstanding_d, outstanding_q;
    logic       kill_d, kill_q;

    pc_t  fetch_pc;
    logic pc_advance, pc_redirect, pc_restore, redir_capture;
    logic req_accept, rsp_take;

    pc_gen #(.RESET_PC(RESET_PC)) u_pc_gen (
        .clk      (clk),
        .rst      (rst),
        .advance  (pc_advance),
        .redirect (pc_redirect),
        .restore  (pc_restore),
        .capture  (redir_capture),
        .branch_pc(branch_pc),
        .fetch_pc (fetch_pc)
    );

    assign req_accept = (state_q == ST_REQ) && imem_ready;
    assign rsp_take   = (state_q == ST_WAIT) && outstanding_q && imem_rsp_valid;

    always_comb begin
        state_d       = state_q;
        pkt_d         = pkt_q;
        pkt_valid_d   = pkt_valid_q;
        outstanding_d = outstanding_q;
        kill_d        = kill_q;
        pc_advance    = 1'b0;
        pc_redirect   = 1'b0;
        pc_restore    = 1'b0;
        redir_capture = 1'b0;

        if (req_accept) outstanding_d = 1'b1;
        if (rsp_take)   outstanding_d = 1'b0;

        unique case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ:  if (req_accept) state_d = ST_WAIT;
            ST_WAIT: begin
                if (rsp_take) begin
                    if (kill_q) begin
                        kill_d     = 1'b0;
                        pc_restore = 1'b1;
                        state_d    = ST_REQ;
                    end else begin
                        pkt_d       = build_packet(fetch_pc, imem_rsp_data);
                        pkt_valid_d = 1'b1;
                        state_d     = ST_PKT;
                    end
                end
            end
            ST_PKT: begin
                if (!instbuf_full) begin
                    pkt_valid_d = 1'b0;
                    pc_advance  = 1'b1;
                    state_d     = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A request already on the bus must keep its address, so the target is parked
        // until the stale response drains; otherwise the redirect takes effect at once.
        if (branch_flag) begin
            pkt_valid_d = 1'b0;
            if ((state_q == ST_REQ) || ((state_q == ST_WAIT) && !rsp_take)) begin
                kill_d        = 1'b1;
                redir_capture = 1'b1;
            end else begin
                pc_redirect = 1'b1;
                pc_restore  = 1'b0;
                pc_advance  = 1'b0;
                kill_d      = 1'b0;
                state_d     = ST_REQ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            pkt_q         <= '0;
            pkt_valid_q   <= 1'b0;
            outstanding_q <= 1'b0;
            kill_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pkt_q         <= pkt_d;
            pkt_valid_q   <= pkt_valid_d;
            outstanding_q <= outstanding_d;
            kill_q        <= kill_d;
        end
    end

    assign imem_req  = (state_q == ST_REQ);
    assign imem_addr = {fetch_pc[PC_W-1:3], 3'b000};
    // The buffer flushes on the same cycle as branch_flag, so nothing may be offered then.
    assign issue     = (pkt_valid_q && !branch_flag) ? pkt_q.mask : ISSUE_NONE;
    assign in1_inst  = pkt_q.inst1;
    assign in1_pc    = pkt_q.pc1;
    assign in1_npc   = pkt_q.npc1;
    assign in2_inst  = pkt_q.inst2;
    assign in2_pc    = pkt_q.pc2;
    assign in2_npc   = pkt_q.npc2;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by randomized
// memory latency, back-pressure and redirects, checked against a fetch-stream model.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        branch_flag;
    logic [31:0] branch_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rsp_valid;
    logic [63:0] imem_rsp_data;
    logic        instbuf_full;
    logic [1:0]  issue;
    logic [31:0] in1_inst, in1_pc, in1_npc;
    logic [31:0] in2_inst, in2_pc, in2_npc;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .branch_flag   (branch_flag),
        .branch_pc     (branch_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .instbuf_full  (instbuf_full),
        .issue         (issue),
        .in1_inst      (in1_inst),
        .in1_pc        (in1_pc),
        .in1_npc       (in1_npc),
        .in2_inst      (in2_inst),
        .in2_pc        (in2_pc),
        .in2_npc       (in2_npc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Stimulus knobs.
    int          cyc        = 0;
    bit          rst_k      = 1'b0;
    int          ready_mode = 0;   // 0 always ready, 1 random, 2 never
    int          lat_min    = 0;
    int          lat_max    = 0;
    bit          full_force = 1'b0;
    bit          rand_full  = 1'b0;
    bit          rand_br    = 1'b0;
    bit          br_now     = 1'b0;
    logic [31:0] br_target  = '0;

    // Memory model: in-order queue of accepted line addresses with due cycles.
    logic [31:0] pend_addr[$];
    int          pend_due[$];

    // Fetch-stream model state.
    logic [31:0]  exp_pc = RESET_PC;
    bit           hold_v = 1'b0;
    logic [193:0] hold_pkt;
    bit           stall_v = 1'b0;
    logic [31:0]  stall_addr;
    int           n_pkt = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [193:0] pack_out();
        return {issue, in1_inst, in1_pc, in1_npc, in2_inst, in2_pc, in2_npc};
    endfunction

    // Expected packet for an instruction stream resuming at pc.
    function automatic logic [193:0] model_pkt(input logic [31:0] pc);
        logic [31:0] base;
        base = {pc[31:3], 3'b000};
        if (pc[2] == 1'b0)
            return {2'b11, mem_word(base), pc, pc + 32'd4, mem_word(base + 32'd4), pc + 32'd4, pc + 32'd8};
        return {2'b01, 96'd0, mem_word(base + 32'd4), pc, pc + 32'd4};
    endfunction

    task automatic observe();
        logic [193:0] cur;
        logic [193:0] exp;
        cur = pack_out();
        if (branch_flag) check("br_issue", 200'(issue), 200'(0));
        if (hold_v) begin
            exp = hold_pkt;
            if (branch_flag) exp[193:192] = 2'b00;
            check("hold", {imem_req, cur}, {1'b0, exp});
        end
        if (stall_v) check("stall", {imem_req, imem_addr}, {1'b1, stall_addr});
        if (issue != 2'b00 && !instbuf_full) begin
            check("pkt", cur, model_pkt(exp_pc));
            exp_pc = {exp_pc[31:3], 3'b000} + 32'd8;
            n_pkt++;
        end
        if (branch_flag) exp_pc = branch_pc;
        hold_v     = (issue != 2'b00) && instbuf_full && !branch_flag;
        hold_pkt   = cur;
        stall_v    = imem_req && !imem_ready;
        stall_addr = imem_addr;
    endtask

    // One clock cycle: drive inputs after the falling edge, then evaluate what the
    // next rising edge will see.
    task automatic cycle();
        logic [31:0] tgt;
        @(negedge clk);
        cyc++;
        rst = rst_k;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = {mem_word(pend_addr[0] + 32'd4), mem_word(pend_addr[0])};
        end
        case (ready_mode)
            0:       imem_ready = 1'b1;
            1:       imem_ready = ($urandom_range(3) != 0);
            default: imem_ready = 1'b0;
        endcase
        instbuf_full = full_force || (rand_full && $urandom_range(3) == 0);
        tgt = $urandom & 32'h0000_03FC;
        if ($urandom_range(3) == 0) tgt = tgt | 32'hFFFF_FC00;
        branch_flag = br_now || (rand_br && $urandom_range(15) == 0);
        branch_pc   = br_now ? br_target : tgt;
        br_now = 1'b0;
        #1;
        if (rst) begin
            observe();
        end else begin
            exp_pc  = RESET_PC;
            hold_v  = 1'b0;
            stall_v = 1'b0;
        end
        if (imem_rsp_valid) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        if (rst && imem_req && imem_ready) begin
            pend_addr.push_back(imem_addr);
            pend_due.push_back(cyc + 1 + int'($urandom_range(lat_max, lat_min)));
        end
    endtask

    task automatic wait_issue(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle();
            seen = (issue != 2'b00);
        end
        check(tag, 200'(seen), 200'(1));
    endtask

    initial begin
        int           t_prev;
        logic [193:0] snap;
        rst = 1'b0;
        branch_flag = 1'b0;
        branch_pc = '0;
        imem_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        instbuf_full = 1'b0;

        // Reset and first request timing.
        repeat (3) cycle();
        check("rst_out", {imem_req, pack_out()}, '0);
        rst_k = 1'b1;
        cycle();
        check("req_c1", 200'(imem_req), 200'(0));
        cycle();
        check("req_c2", {imem_req, imem_addr}, {1'b1, RESET_PC});
        t_prev = cyc;

        // Zero-wait stream: one packet every three cycles.
        wait_issue("pkt0_wait");
        check("pkt0_time", 200'(cyc - t_prev), 200'(2));
        check("pkt0", {issue, in1_pc, in1_npc, in2_pc, in2_npc},
              {2'b11, 32'h0, 32'h4, 32'h4, 32'h8});
        t_prev = cyc;
        full_force = 1'b1;
        wait_issue("pkt1_wait");
        check("pkt1_time", 200'(cyc - t_prev), 200'(3));
        check("pkt1", {issue, in1_pc, in1_npc, in2_pc, in2_npc},
              {2'b11, 32'h8, 32'hC, 32'hC, 32'h10});

        // Back-pressure: packet held bit-identical for five cycles.
        snap = pack_out();
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("full_hold", {imem_req, pack_out()}, {1'b0, snap});
        end
        full_force = 1'b0;
        cycle();
        check("full_rel", {imem_req, pack_out()}, {1'b0, snap});
        t_prev = cyc;
        cycle();
        check("req_after_full", {imem_req, imem_addr}, {1'b1, 32'h10});
        wait_issue("pkt2_wait");
        check("pkt2_time", 200'(cyc - t_prev), 200'(3));
        check("pkt2", {issue, in1_pc, in2_pc}, {2'b11, 32'h10, 32'h14});

        // Redirect to a mid-block target while a packet sits in the buffer port.
        full_force = 1'b1;
        wait_issue("pkt3_wait");
        br_now = 1'b1;
        br_target = 32'h104;
        cycle();
        check("br_drop", 200'(issue), 200'(0));
        full_force = 1'b0;
        cycle();
        check("br_req", {imem_req, imem_addr}, {1'b1, 32'h100});
        wait_issue("br_pkt_wait");
        check("br_pkt", {issue, in1_inst, in1_pc, in1_npc, in2_inst, in2_pc, in2_npc},
              {2'b01, 96'd0, mem_word(32'h104), 32'h104, 32'h108});
        lat_min = 3;
        lat_max = 3;
        cycle();
        check("br_seq_req", {imem_req, imem_addr}, {1'b1, 32'h108});

        // Redirect while waiting: stale response three cycles later is discarded.
        br_now = 1'b1;
        br_target = 32'h200;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("kill_quiet", {issue, imem_req}, '0);
        end
        lat_min = 0;
        lat_max = 0;
        cycle();
        check("kill_req", {imem_req, imem_addr}, {1'b1, 32'h200});
        wait_issue("kill_pkt_wait");
        check("kill_pkt", {issue, in1_pc}, {2'b11, 32'h200});

        // Memory stall with a redirect in the middle of it.
        ready_mode = 2;
        cycle();
        check("stall_addr", {imem_req, imem_addr}, {1'b1, 32'h208});
        for (int i = 1; i < 4; i++) begin
            if (i == 1) begin
                br_now = 1'b1;
                br_target = 32'h300;
            end
            cycle();
            check("stall_hold", {imem_req, imem_addr, issue}, {1'b1, 32'h208, 2'b00});
        end
        ready_mode = 0;
        cycle();
        check("stall_accept", {imem_req, imem_addr}, {1'b1, 32'h208});
        cycle();
        check("stall_kill", {imem_req, issue}, '0);
        cycle();
        check("stall_redir", {imem_req, imem_addr}, {1'b1, 32'h300});
        wait_issue("stall_pkt_wait");
        check("stall_pkt", {issue, in1_pc}, {2'b11, 32'h300});

        // Reset while waiting; the late response must not produce a packet.
        lat_min = 1;
        lat_max = 1;
        cycle();
        check("rst_req", {imem_req, imem_addr}, {1'b1, 32'h308});
        rst_k = 1'b0;
        cycle();
        rst_k = 1'b1;
        cycle();
        check("rst_late_rsp", {imem_rsp_valid, issue, imem_req}, {1'b1, 3'b000});
        cycle();
        check("rst_restart", {imem_req, imem_addr, issue}, {1'b1, RESET_PC, 2'b00});
        lat_min = 0;
        lat_max = 0;
        wait_issue("rst_pkt_wait");
        check("rst_pkt", {issue, in1_pc}, {2'b11, RESET_PC});

        // Randomized traffic against the stream model.
        t_prev     = n_pkt;
        ready_mode = 1;
        lat_min    = 0;
        lat_max    = 3;
        rand_full  = 1'b1;
        rand_br    = 1'b1;
        repeat (3000) cycle();
        check("progress", 200'(n_pkt - t_prev > 50), 200'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
